// File: rtl/uart_tx_arbiter_pkg.sv
// Shared UART definitions: arbiter state encoding and default sizing used by the
// transmitter, the senders and the transmit arbiter.
package uart_tx_arbiter_pkg;

  // Number of byte-stream requesters sharing one transmitter.
  localparam int unsigned UartNReqDefault    = 3;
  // Silent cycles a granted requester may hold the transmitter before losing it.
  localparam int unsigned UartTimeoutDefault = 50000;

  typedef enum logic [0:0] {
    StIdle = 1'b0,  // no owner, arbitrating
    StSend = 1'b1   // frame locked to one requester
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: picks the first requesting bit at or
// above ptr_i, wrapping to bit 0 when nothing at or above the pointer is requesting.
module uart_tx_arbiter_rr_pick #(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned PtrW  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PtrW-1:0]  ptr_i,
  output logic [N_REQ-1:0] winner_o,
  output logic             any_o
);

  logic [N_REQ-1:0] mask;
  logic [N_REQ-1:0] req_hi;
  logic [N_REQ-1:0] pick;

  // Prefer requesters at/above the pointer, then isolate the lowest set bit.
  always_comb begin
    mask = '0;
    for (int i = 0; i < N_REQ; i++) begin
      mask[i] = (i >= int'(ptr_i));
    end
    req_hi   = req_i & mask;
    pick     = (|req_hi) ? req_hi : req_i;
    winner_o = pick & (~pick + N_REQ'(1));
    any_o    = |req_i;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that locks the UART transmitter to one requester for a whole
// frame, forwards one byte per handshake as a single-cycle strobe, and revokes the
// grant if the owner stays silent for too long.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ   = UartNReqDefault,
  parameter int unsigned TIMEOUT = UartTimeoutDefault
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid_i,
  input  logic [8*N_REQ-1:0] req_data_i,
  input  logic [N_REQ-1:0]   req_last_i,
  output logic [N_REQ-1:0]   req_ready_o,
  input  logic               uart_ready_i,
  output logic [7:0]         tx_data_o,
  output logic               tx_valid_o,
  output logic [N_REQ-1:0]   grant_o,
  output logic               busy_o,
  output logic               timeout_err_o
);

  localparam int unsigned PtrW = $clog2(N_REQ);
  localparam int unsigned CntW = $clog2(TIMEOUT);

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [PtrW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0]  idle_cnt_q, idle_cnt_d;
  logic             tx_valid_q, tx_valid_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             timeout_err_q, timeout_err_d;

  logic [N_REQ-1:0] win;
  logic             win_any;
  logic             own_valid;
  logic             own_last;
  logic [7:0]       own_data;
  logic [PtrW-1:0]  own_next;
  logic             handshake;
  logic             idle_cycle;
  logic             timeout_hit;

  uart_tx_arbiter_rr_pick #(
    .N_REQ (N_REQ),
    .PtrW  (PtrW)
  ) u_rr_pick (
    .req_i    (req_valid_i),
    .ptr_i    (rr_ptr_q),
    .winner_o (win),
    .any_o    (win_any)
  );

  // Owner's stream fields and the pointer value that follows the owner.
  always_comb begin
    own_valid = |(req_valid_i & grant_q);
    own_last  = |(req_last_i & grant_q);
    own_data  = '0;
    own_next  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) begin
        own_data = req_data_i[8*i +: 8];
        own_next = PtrW'((i + 1) % N_REQ);
      end
    end
  end

  // Handshake and silence qualifiers; a silent owner cannot also handshake.
  always_comb begin
    handshake   = |req_ready_o;
    idle_cycle  = (state_q == StSend) && uart_ready_i && !tx_valid_q && !own_valid;
    timeout_hit = idle_cycle && (idle_cnt_q == CntW'(TIMEOUT - 1));
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: lock on a winner, release on last byte or timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (win_any) state_d = StSend;
      StSend: if ((handshake && own_last) || timeout_hit) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: only the owner may be accepted, and never while a strobe is out.
  always_comb begin
    busy_o      = (state_q == StSend);
    req_ready_o = '0;
    if ((state_q == StSend) && uart_ready_i && !tx_valid_q) begin
      req_ready_o = grant_q & req_valid_i;
    end
  end

  // Datapath next state: grant, pointer, idle counter and transmit strobe.
  always_comb begin
    grant_d       = grant_q;
    rr_ptr_d      = rr_ptr_q;
    idle_cnt_d    = idle_cnt_q;
    tx_data_d     = tx_data_q;
    tx_valid_d    = 1'b0;
    timeout_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        idle_cnt_d = '0;
        if (win_any) grant_d = win;
      end
      StSend: begin
        if (handshake) begin
          tx_valid_d = 1'b1;
          tx_data_d  = own_data;
          idle_cnt_d = '0;
          if (own_last) begin
            grant_d  = '0;
            rr_ptr_d = own_next;
          end
        end else if (timeout_hit) begin
          grant_d       = '0;
          rr_ptr_d      = own_next;
          idle_cnt_d    = '0;
          timeout_err_d = 1'b1;
        end else if (idle_cycle) begin
          idle_cnt_d = idle_cnt_q + CntW'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset discards any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q       <= '0;
      rr_ptr_q      <= '0;
      idle_cnt_q    <= '0;
      tx_valid_q    <= 1'b0;
      tx_data_q     <= 8'h00;
      timeout_err_q <= 1'b0;
    end else begin
      grant_q       <= grant_d;
      rr_ptr_q      <= rr_ptr_d;
      idle_cnt_q    <= idle_cnt_d;
      tx_valid_q    <= tx_valid_d;
      tx_data_q     <= tx_data_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign grant_o       = grant_q;
  assign tx_valid_o    = tx_valid_q;
  assign tx_data_o     = tx_data_q;
  assign timeout_err_o = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed frames plus randomized traffic, checked every
// cycle against a behavioural model of the arbitration rules.
module tb_uart_tx_arbiter;

  localparam int NR = 3;
  localparam int TO = 8;

  logic            clk;
  logic            rst;
  logic [NR-1:0]   req_valid;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0]   req_last;
  logic [NR-1:0]   req_ready;
  logic            uart_ready;
  logic [7:0]      tx_data;
  logic            tx_valid;
  logic [NR-1:0]   grant;
  logic            busy;
  logic            timeout_err;

  uart_tx_arbiter #(
    .N_REQ   (NR),
    .TIMEOUT (TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid_i   (req_valid),
    .req_data_i    (req_data),
    .req_last_i    (req_last),
    .req_ready_o   (req_ready),
    .uart_ready_i  (uart_ready),
    .tx_data_o     (tx_data),
    .tx_valid_o    (tx_valid),
    .grant_o       (grant),
    .busy_o        (busy),
    .timeout_err_o (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expire(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: wait bound expired before the expected event (cycle %0d)", name, cyc);
  endtask

  // ---------------- behavioural model ----------------
  int         m_owner = -1;  // index of frame owner, -1 when nobody holds the UART
  int         m_ptr   = 0;   // first requester considered at the next arbitration
  int         m_idle  = 0;   // consecutive silent cycles of the owner
  bit         m_txv   = 0;
  logic [7:0] m_txd   = 8'h00;
  bit         m_terr  = 0;
  bit         m_was_txv;
  int         m_j;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_idle = 0; m_txv = 0; m_txd = 8'h00; m_terr = 0;
    end else begin
      m_was_txv = m_txv;
      m_txv     = 0;
      m_terr    = 0;
      if (m_owner < 0) begin
        for (int k = 0; k < NR; k++) begin
          m_j = (m_ptr + k) % NR;
          if (m_owner < 0 && req_valid[m_j]) m_owner = m_j;
        end
        m_idle = 0;
      end else if (req_valid[m_owner] && uart_ready && !m_was_txv) begin
        m_txv  = 1;
        m_txd  = req_data[8*m_owner +: 8];
        m_idle = 0;
        if (req_last[m_owner]) begin
          m_ptr   = (m_owner + 1) % NR;
          m_owner = -1;
        end
      end else if (uart_ready && !m_was_txv && !req_valid[m_owner]) begin
        m_idle++;
        if (m_idle == TO) begin
          m_terr  = 1;
          m_ptr   = (m_owner + 1) % NR;
          m_owner = -1;
          m_idle  = 0;
        end
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    logic [NR-1:0] e_grant;
    logic [NR-1:0] e_rdy;
    e_grant = (m_owner < 0) ? '0 : (NR'(1) << m_owner);
    e_rdy   = '0;
    if (m_owner >= 0 && req_valid[m_owner] && uart_ready && !m_txv) e_rdy = e_grant;
    check("grant", 32'(grant), 32'(e_grant));
    check("busy", 32'(busy), 32'(m_owner >= 0));
    check("req_ready", 32'(req_ready), 32'(e_rdy));
    check("tx_valid", 32'(tx_valid), 32'(m_txv));
    check("tx_data", 32'(tx_data), 32'(m_txd));
    check("timeout_err", 32'(timeout_err), 32'(m_terr));
  end

  // ---------------- requester sources ----------------
  typedef struct {
    int         cyc;
    logic [7:0] d;
  } cap_t;

  logic [8:0] src_mem[NR][256];
  int         head[NR];
  int         tail[NR];
  bit         hold[NR];
  int         drop[NR];
  bit         rand_mode = 0;
  cap_t       cap[$];
  int         terr_cnt = 0;
  int         terr_cyc = 0;

  task automatic push(input int r, input logic [7:0] d, input bit l);
    src_mem[r][tail[r] % 256] = {l, d};
    tail[r]++;
  endtask

  task automatic push_frame(input int r, input string s);
    for (int k = 0; k < s.len(); k++) push(r, 8'(s[k]), k == s.len() - 1);
  endtask

  task automatic clear_sources();
    for (int i = 0; i < NR; i++) begin
      head[i] = 0; tail[i] = 0; hold[i] = 0; drop[i] = 0;
    end
    req_valid = '0;
  endtask

  // One clock: capture registered outputs, retire accepted bytes, present next ones.
  task automatic step();
    logic [NR-1:0] hs;
    bit            gate;
    int            len;
    @(negedge clk);
    hs = req_valid & req_ready;
    @(posedge clk);
    #1;
    if (tx_valid) cap.push_back('{cyc: cyc, d: tx_data});
    if (timeout_err) begin
      terr_cnt++;
      terr_cyc = cyc;
    end
    for (int i = 0; i < NR; i++) if (hs[i]) head[i]++;
    if (rand_mode) begin
      uart_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NR; i++) begin
        if (head[i] == tail[i] && $urandom_range(0, 7) == 0) begin
          len = $urandom_range(1, 4);
          for (int k = 0; k < len; k++) push(i, 8'($urandom), k == len - 1);
        end
      end
    end
    for (int i = 0; i < NR; i++) begin
      gate = 1;
      if (rand_mode) begin
        if (drop[i] > 0) begin
          gate = 0;
          drop[i]--;
        end else if ($urandom_range(0, 63) == 0) begin
          drop[i] = 12;
          gate    = 0;
        end else begin
          gate = ($urandom_range(0, 7) != 0);
        end
      end
      if (head[i] != tail[i] && !hold[i] && gate) begin
        req_valid[i] = 1'b1;
        {req_last[i], req_data[8*i +: 8]} = src_mem[i][head[i] % 256];
      end else begin
        req_valid[i]         = 1'b0;
        req_last[i]          = 1'($urandom_range(0, 1));
        req_data[8*i +: 8]   = 8'($urandom);
      end
    end
  endtask

  function automatic bit sources_empty();
    for (int i = 0; i < NR; i++) if (head[i] != tail[i]) return 0;
    return 1;
  endfunction

  task automatic run_until_idle(input string name);
    int n = 0;
    while (!(sources_empty() && grant == '0 && !tx_valid) && n < 400) begin
      step();
      n++;
    end
    if (n >= 400) expire(name);
  endtask

  task automatic wait_cap(input int want, input string name);
    int n = 0;
    while (cap.size() < want && n < 200) begin
      step();
      n++;
    end
    if (cap.size() < want) expire(name);
  endtask

  task automatic check_bytes(input string name, input string s);
    check({name, "_count"}, 32'(cap.size()), 32'(s.len()));
    for (int k = 0; k < s.len() && k < cap.size(); k++) begin
      check({name, "_byte"}, 32'(cap[k].d), 32'(8'(s[k])));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    clear_sources();
    rst = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int t0;
    int t_last;
    int e0;
    int n;
    rst        = 1'b1;
    req_valid  = '0;
    req_data   = '0;
    req_last   = '0;
    uart_ready = 1'b0;
    clear_sources();
    repeat (3) @(posedge clk);
    #1;
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_tx_valid", 32'(tx_valid), 32'h0);
    check("rst_tx_data", 32'(tx_data), 32'h0);
    check("rst_timeout_err", 32'(timeout_err), 32'h0);
    check("rst_req_ready", 32'(req_ready), 32'h0);
    rst        = 1'b0;
    uart_ready = 1'b1;

    // Single requester sends "2024": latency 2, one strobe every second cycle.
    cap.delete();
    push_frame(0, "2024");
    step();
    t0 = cyc;
    run_until_idle("2024_drain");
    check_bytes("2024", "2024");
    if (cap.size() >= 4) begin
      check("2024_latency", 32'(cap[0].cyc - t0), 32'd2);
      for (int k = 1; k < 4; k++) check("2024_spacing", 32'(cap[k].cyc - cap[k-1].cyc), 32'd2);
    end
    check("2024_grant_end", 32'(grant), 32'h0);

    // Pointer now at 1: requester 1 beats requester 0.
    cap.delete();
    push_frame(0, "x");
    push_frame(1, "y");
    step();
    step();
    check("ptr1_grant", 32'(grant), 32'b010);
    run_until_idle("ptr1_drain");
    check_bytes("ptr1", "yx");

    // Requesters 0 and 2 from reset; 0 re-requests and must wait for 2's frame.
    do_reset();
    cap.delete();
    push_frame(0, "abc");
    push_frame(0, "de");
    push_frame(2, "CDE");
    step();
    run_until_idle("rr_drain");
    check_bytes("rr", "abcCDEde");

    // Transmitter stalls for 100 cycles mid-frame; no strobe, no timeout.
    cap.delete();
    push_frame(1, "pqrs");
    wait_cap(2, "stall_first");
    uart_ready = 1'b0;
    e0 = terr_cnt;
    repeat (100) step();
    check("stall_no_tx", 32'(cap.size()), 32'd2);
    check("stall_no_timeout", 32'(terr_cnt - e0), 32'd0);
    check("stall_busy", 32'(busy), 32'h1);
    check("stall_grant", 32'(grant), 32'b010);
    uart_ready = 1'b1;
    run_until_idle("stall_drain");
    check_bytes("stall", "pqrs");

    // Reset during the third byte of requester 2's frame.
    cap.delete();
    push_frame(2, "VWXYZ");
    wait_cap(3, "midrst_third");
    rst = 1'b1;
    #1;
    check("midrst_grant", 32'(grant), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_tx_valid", 32'(tx_valid), 32'h0);
    check("midrst_tx_data", 32'(tx_data), 32'h0);
    check("midrst_timeout_err", 32'(timeout_err), 32'h0);
    check("midrst_req_ready", 32'(req_ready), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    clear_sources();
    rst = 1'b0;
    cap.delete();
    push_frame(1, "AB");
    push_frame(2, "Z");
    step();
    run_until_idle("postrst_drain");
    check_bytes("postrst", "ABZ");

    // Owner 0 goes silent after two bytes; grant revoked after 8 idle cycles.
    cap.delete();
    push_frame(0, "ghijk");
    push_frame(1, "N");
    e0 = terr_cnt;
    wait_cap(2, "to_first");
    t_last = (cap.size() >= 2) ? cap[1].cyc : cyc;
    hold[0] = 1;
    n = 0;
    while (terr_cnt == e0 && n < 60) begin
      step();
      n++;
    end
    if (terr_cnt == e0) expire("to_pulse");
    check("to_delay", 32'(terr_cyc - t_last), 32'd9);
    check("to_grant", 32'(grant), 32'h0);
    check("to_err", 32'(timeout_err), 32'h1);
    head[0] = tail[0];
    hold[0] = 0;
    run_until_idle("to_drain");
    check_bytes("to_next", "ghN");

    // Randomized traffic with one reset in the middle.
    rand_mode = 1;
    for (int k = 0; k < 3000; k++) begin
      if (k == 1500) do_reset();
      step();
    end
    rand_mode  = 0;
    uart_ready = 1'b1;
    repeat (2) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
